axis_tx_pktbuf: RTL

Store-and-forward packet buffer for the 64-bit AXI-Stream transmit path. It accepts frames on a slave AXIS port that never back-pressures. Only frames that arrive complete and error-free are released to `m_axis_tx_*`, and the output honours `m_axis_tx_tready` beat by beat. Errored frames (`tuser=1` at `tlast`) and frames that do not fit are discarded whole. The block sits between a producer that cannot stall and the TX MAC interface, which can.

---
 rtl/axis_tx_pktbuf.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/axis_tx_pktbuf.sv
// Store-and-forward AXI-Stream TX packet buffer: only complete, error-free frames are released.
// Define AXIS_TXBUF_STATS_EN to build the frame_tx_cnt / frame_drop_cnt statistics counters.
module axis_tx_pktbuf #(
   parameter int unsigned DEPTH_LOG2 = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_axis_tx_tvalid,
   output logic        s_axis_tx_tready,
   input  logic [63:0] s_axis_tx_tdata,
   input  logic [7:0]  s_axis_tx_tkeep,
   input  logic        s_axis_tx_tlast,
   input  logic        s_axis_tx_tuser,
   input  logic        m_axis_tx_tready,
   output logic        m_axis_tx_tvalid,
   output logic [63:0] m_axis_tx_tdata,
   output logic [7:0]  m_axis_tx_tkeep,
   output logic        m_axis_tx_tlast,
   output logic        m_axis_tx_tuser,
   output logic [31:0] frame_tx_cnt,
   output logic [31:0] frame_drop_cnt
);
   localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam int unsigned WordW = 73;
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [PtrW-1:0] PtrFull = PtrW'(Depth);

   logic [WordW-1:0] mem_q [Depth];

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  commit_ptr_q, commit_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic             drop_q, drop_d;
   logic [WordW-1:0] ram_data_q, ram_data_d;
   logic             ram_valid_q, ram_valid_d;
   logic [WordW-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;

   logic [PtrW-1:0]  used;
   logic             full;
   logic             wr_en;
   logic             frame_done;
   logic             frame_bad;
   logic             out_load;
   logic             fetch;

   // Write side: partial frames live between commit_ptr and wr_ptr until tlast decides them.
   always_comb begin
      used         = wr_ptr_q - rd_ptr_q;
      full         = (used == PtrFull);
      wr_en        = s_axis_tx_tvalid && !full && !drop_q;
      frame_done   = s_axis_tx_tvalid && s_axis_tx_tlast;
      frame_bad    = frame_done && (drop_q || s_axis_tx_tuser || !wr_en);
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      drop_d       = drop_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (frame_done) begin
         drop_d = 1'b0;
         if (frame_bad) begin
            wr_ptr_d = commit_ptr_q;
         end else begin
            commit_ptr_d = wr_ptr_q + PtrOne;
         end
      end else if (s_axis_tx_tvalid && full) begin
         drop_d = 1'b1;
      end
   end

   // Read side: RAM output register feeding an output holding register.
   always_comb begin
      out_load    = !out_valid_q || m_axis_tx_tready;
      fetch       = (rd_ptr_q != commit_ptr_q) && (!ram_valid_q || out_load);
      rd_ptr_d    = fetch ? rd_ptr_q + PtrOne : rd_ptr_q;
      ram_data_d  = fetch ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : ram_data_q;
      ram_valid_d = ram_valid_q;
      if (fetch) begin
         ram_valid_d = 1'b1;
      end else if (out_load) begin
         ram_valid_d = 1'b0;
      end
      out_valid_d = out_load ? ram_valid_q : out_valid_q;
      out_data_d  = (out_load && ram_valid_q) ? ram_data_q : out_data_q;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         drop_q       <= 1'b0;
         ram_data_q   <= '0;
         ram_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         drop_q       <= drop_d;
         ram_data_q   <= ram_data_d;
         ram_valid_q  <= ram_valid_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign s_axis_tx_tready = !rst;
   assign m_axis_tx_tvalid = out_valid_q;
   assign m_axis_tx_tlast  = out_data_q[72];
   assign m_axis_tx_tkeep  = out_data_q[71:64];
   assign m_axis_tx_tdata  = out_data_q[63:0];
   assign m_axis_tx_tuser  = 1'b0;

`ifdef AXIS_TXBUF_STATS_EN
   logic [31:0] tx_cnt_q, tx_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      tx_cnt_d   = tx_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (out_valid_q && m_axis_tx_tready && out_data_q[72]) begin
         tx_cnt_d = tx_cnt_q + 32'd1;
      end
      if (frame_bad) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         tx_cnt_q   <= tx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign frame_tx_cnt   = tx_cnt_q;
   assign frame_drop_cnt = drop_cnt_q;
`else
   assign frame_tx_cnt   = '0;
   assign frame_drop_cnt = '0;
`endif

endmodule
